// File: rtl/top_alu_interface.sv
// Switch-loaded ALU wrapper: two buttons pick a target register and load it
// from the switches; the ALU result drives the LEDs continuously.
module top_alu_interface #(
    parameter int NB_OP   = 6,
    parameter int NB_DATA = 8
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] switches,
    input  logic               btn_select,
    input  logic               btn_set,
    output logic [NB_DATA-1:0] leds
);

    typedef enum logic [1:0] {
        SEL_A  = 2'd0,
        SEL_B  = 2'd1,
        SEL_OP = 2'd2
    } sel_t;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

    logic [NB_DATA-1:0] r_a;
    logic [NB_DATA-1:0] r_b;
    logic [NB_OP-1:0]   r_op;
    sel_t               r_sel;
    logic               r_prev_select;
    logic               r_prev_set;

    logic               w_select_press;
    logic               w_set_press;
    logic [NB_DATA-1:0] w_alu;

    // Rising-edge detect against the live input; buttons are already synchronous.
    assign w_select_press = btn_select & ~r_prev_select;
    assign w_set_press    = btn_set & ~r_prev_set;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_prev_select <= 1'b0;
            r_prev_set    <= 1'b0;
        end else begin
            r_prev_select <= btn_select;
            r_prev_set    <= btn_set;
        end
    end

    // Load uses the pre-advance target when both buttons fire together.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sel <= SEL_A;
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
        end else begin
            if (w_set_press) begin
                case (r_sel)
                    SEL_A:   r_a  <= switches;
                    SEL_B:   r_b  <= switches;
                    SEL_OP:  r_op <= switches[NB_OP-1:0];
                    default: ;
                endcase
            end
            if (w_select_press) begin
                case (r_sel)
                    SEL_A:   r_sel <= SEL_B;
                    SEL_B:   r_sel <= SEL_OP;
                    SEL_OP:  r_sel <= SEL_A;
                    default: r_sel <= SEL_A;
                endcase
            end
        end
    end

    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            OP_AND:  w_alu = r_a & r_b;
            OP_OR:   w_alu = r_a | r_b;
            OP_XOR:  w_alu = r_a ^ r_b;
            OP_NOR:  w_alu = ~(r_a | r_b);
            OP_SRA:  w_alu = $signed(r_a) >>> r_b;
            OP_SRL:  w_alu = r_a >> r_b;
            default: w_alu = '0;
        endcase
    end

    assign leds = w_alu;

endmodule

// File: tb/tb_top_alu_interface.sv
// Directed bench for the switch-loaded ALU wrapper; expected LED values
// are queued when stimulus is applied and compared once the DUT updates.
module tb_top_alu_interface;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] switches;
    logic       btn_select;
    logic       btn_set;
    logic [7:0] leds;

    logic [7:0] sb[$];
    int         n_chk  = 0;
    int         n_pass = 0;

    top_alu_interface #(.NB_OP(6), .NB_DATA(8)) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .switches   (switches),
        .btn_select (btn_select),
        .btn_set    (btn_set),
        .leds       (leds)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic expect_led(input logic [7:0] v);
        sb.push_back(v);
    endtask

    task automatic check(input string tag);
        logic [7:0] exp;
        n_chk++;
        if (sb.size() == 0) begin
            $error("FAIL %s: scoreboard empty, leds=%h", tag, leds);
        end else begin
            exp = sb.pop_front();
            assert (leds === exp) n_pass++;
            else $error("FAIL %s: leds=%h expected=%h", tag, leds, exp);
        end
    endtask

    task automatic press_select();
        @(negedge clk);
        btn_select = 1'b1;
        @(negedge clk);
        btn_select = 1'b0;
    endtask

    task automatic press_set(input logic [7:0] v);
        @(negedge clk);
        switches = v;
        btn_set  = 1'b1;
        @(negedge clk);
        btn_set  = 1'b0;
    endtask

    // Starts at A, ends at A again after loading all three registers.
    task automatic load3(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] exp,
                         input string tag);
        press_set(a);
        press_select();
        press_set(b);
        press_select();
        press_set(op);
        expect_led(exp);
        check(tag);
        press_select();
    endtask

    initial begin
        i_reset    = 1'b0;
        switches   = '0;
        btn_select = 1'b0;
        btn_set    = 1'b0;
        #12;
        expect_led(8'h00);
        check("reset_leds");
        @(negedge clk);
        i_reset = 1'b1;

        // case 1: ADD
        press_set(8'h0A);
        expect_led(8'h00);
        check("op0_unmapped");
        press_select();
        press_set(8'h05);
        press_select();
        press_set(8'h20);
        expect_led(8'h0F);
        check("add_0a_05");

        // case 2: SUB wrap, intermediate ADD results
        press_select();
        press_set(8'h05);
        expect_led(8'h0A);
        check("add_after_a5");
        press_select();
        press_set(8'h0A);
        expect_led(8'h0F);
        check("add_after_b0a");
        press_select();
        press_set(8'h22);
        expect_led(8'hFB);
        check("sub_wrap");
        press_select();

        // case 3: logic, shifts, unmapped, boundaries
        load3(8'hF0, 8'h3C, 8'h24, 8'h30, "and");
        load3(8'hF0, 8'h3C, 8'h25, 8'hFC, "or");
        load3(8'hF0, 8'h3C, 8'h26, 8'hCC, "xor");
        load3(8'hF0, 8'h3C, 8'h27, 8'h03, "nor");
        load3(8'h80, 8'h02, 8'h03, 8'hE0, "sra");
        load3(8'h80, 8'h02, 8'h02, 8'h20, "srl");
        load3(8'h80, 8'h02, 8'h3F, 8'h00, "op3f");
        load3(8'h80, 8'h09, 8'h03, 8'hFF, "sra_big");
        load3(8'h40, 8'h07, 8'h03, 8'h00, "sra_pos_b7");
        load3(8'hFF, 8'h08, 8'h02, 8'h00, "srl_big");
        load3(8'h7F, 8'h01, 8'h20, 8'h80, "add_ovf");
        load3(8'h01, 8'h02, 8'h20, 8'h03, "add_base");

        // case 4: held select advances once
        @(negedge clk);
        btn_select = 1'b1;
        repeat (5) @(negedge clk);
        btn_select = 1'b0;
        press_set(8'h07);
        expect_led(8'h08);
        check("hold_select_once");
        press_select();
        press_select();
        press_select();
        press_set(8'h10);
        expect_led(8'h11);
        check("three_sel_wrap_b");
        press_select();
        press_select();
        press_set(8'h04);
        expect_led(8'h14);
        check("load_a_04");
        press_select();
        press_select();
        press_select();
        press_set(8'h06);
        expect_led(8'h16);
        check("three_sel_wrap_a");

        // case 5: both buttons in one cycle
        @(negedge clk);
        switches   = 8'h33;
        btn_select = 1'b1;
        btn_set    = 1'b1;
        @(negedge clk);
        btn_select = 1'b0;
        btn_set    = 1'b0;
        expect_led(8'h43);
        check("both_load_a");
        press_set(8'h01);
        expect_led(8'h34);
        check("both_sel_now_b");

        // case 6: async reset between edges
        @(posedge clk);
        #2;
        i_reset = 1'b0;
        #1;
        expect_led(8'h00);
        check("async_reset");
        @(negedge clk);
        i_reset = 1'b1;
        press_set(8'h09);
        expect_led(8'h00);
        check("post_reset_op0");
        press_select();
        press_set(8'h01);
        press_select();
        press_set(8'h20);
        expect_led(8'h0A);
        check("post_reset_a09");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
